// File: rtl/qerv_rf_ram_resp.sv
// qerv_rf_ram_resp
// RAM-side responder for the qerv register-file RAM interface. After every
// reset it sweeps the array to zero, then serves one write and one read per
// clock with one cycle of read latency. A low-priority debug read port uses
// the cycles in which the core does not read.
module qerv_rf_ram_resp #(
    parameter  int width    = 8,
    parameter  int csr_regs = 4,
    localparam int raw      = $clog2(32 + csr_regs),
    localparam int l2w      = $clog2(width),
    localparam int aw       = 5 + raw - l2w,
    localparam int depth    = (32 + csr_regs) * 32 / width
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_init_done,
    output logic             o_oob,
    input  logic             i_dbg_req,
    input  logic [aw-1:0]    i_dbg_addr,
    output logic             o_dbg_ack,
    output logic [width-1:0] o_dbg_rdata
);

    // Controller states: zero-sweep after reset, then normal service.
    localparam logic STATE_INIT = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    // One extra bit so the range compare also works when depth == 2**aw.
    localparam logic [aw:0]   DEPTH_W   = (aw + 1)'(depth);
    localparam logic [aw-1:0] LAST_ADDR = aw'(depth - 1);
    localparam logic [aw-1:0] ADDR_ONE  = aw'(1);

    // Storage: only the implemented words exist.
    logic [width-1:0] mem [depth];

    // Controller state and registered outputs.
    logic             state_q,     state_d;
    logic [aw-1:0]    cnt_q,       cnt_d;
    logic [width-1:0] rdata_q,     rdata_d;
    logic             oob_q,       oob_d;
    logic             dbg_ack_q,   dbg_ack_d;
    logic [width-1:0] dbg_rdata_q, dbg_rdata_d;

    // Address decode and array access helpers.
    logic             run;
    logic             w_in_range;
    logic             r_in_range;
    logic             d_in_range;
    logic [aw-1:0]    r_idx;
    logic [aw-1:0]    d_idx;
    logic [width-1:0] core_word;
    logic [width-1:0] dbg_word;
    logic             dbg_fire;

    // Single array write port, shared by the sweep and the core.
    logic             mem_we;
    logic [aw-1:0]    mem_waddr;
    logic [width-1:0] mem_wdata;

    // Range checks, write-first bypass and debug slot detection.
    always_comb begin
        // NOTE: every signal assigned in this block gets a value on every path,
        // starting with these defaults, so no latch can be inferred.
        run        = (state_q == STATE_RUN);
        w_in_range = ({1'b0, i_waddr}    < DEPTH_W);
        r_in_range = ({1'b0, i_raddr}    < DEPTH_W);
        d_in_range = ({1'b0, i_dbg_addr} < DEPTH_W);
        // Out-of-range addresses never index the array; their data is forced to 0.
        r_idx      = r_in_range ? i_raddr    : '0;
        d_idx      = d_in_range ? i_dbg_addr : '0;

        core_word = '0;
        if (r_in_range) begin
            if (i_wen && (i_waddr == i_raddr)) begin
                core_word = i_wdata;
            end else begin
                core_word = mem[r_idx];
            end
        end

        dbg_word = '0;
        if (d_in_range) begin
            if (i_wen && (i_waddr == i_dbg_addr)) begin
                dbg_word = i_wdata;
            end else begin
                dbg_word = mem[d_idx];
            end
        end

        // Debug only gets a slot the core read port leaves free, and never in
        // the cycle its previous ack is showing.
        dbg_fire = run && !i_ren && i_dbg_req && !dbg_ack_q;
    end

    // Next-state logic for the sweep controller, read ports and error flag.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        oob_d       = oob_q;
        dbg_ack_d   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = cnt_q;
        mem_wdata   = '0;

        if (!run) begin
            // Zero one word per clock; core traffic is dropped and flagged.
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            if (cnt_q == LAST_ADDR) begin
                state_d = STATE_RUN;
            end else begin
                cnt_d = cnt_q + ADDR_ONE;
            end
            if (i_wen || i_ren) begin
                oob_d = 1'b1;
            end
        end else begin
            if (i_wen) begin
                if (w_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = i_waddr;
                    mem_wdata = i_wdata;
                end else begin
                    oob_d = 1'b1;
                end
            end

            if (i_ren) begin
                rdata_d = core_word;
                if (!r_in_range) begin
                    oob_d = 1'b1;
                end
            end

            if (dbg_fire) begin
                dbg_ack_d   = 1'b1;
                dbg_rdata_d = dbg_word;
                if (!d_in_range) begin
                    oob_d = 1'b1;
                end
            end
        end
    end

    // Control and output registers; reset restarts the sweep from address 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= STATE_INIT;
            cnt_q       <= '0;
            rdata_q     <= '0;
            oob_q       <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge value of every other flop.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            oob_q       <= oob_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Array write port.
    always_ff @(posedge i_clk) begin
        // NOTE: the array deliberately has no reset so it maps onto an SRAM
        // macro; the post-reset sweep is what defines its contents.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign o_rdata     = rdata_q;
    assign o_init_done = state_q;
    assign o_oob       = oob_q;
    assign o_dbg_ack   = dbg_ack_q;
    assign o_dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_qerv_rf_ram_resp.sv
// Testbench for qerv_rf_ram_resp: directed vector table, hand-written reset
// sequences, and randomized traffic checked against a behavioural model.
module tb_qerv_rf_ram_resp;

    localparam int W     = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 144;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          ren;
    logic [AW-1:0] raddr;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  rdata;
    logic          init_done;
    logic          oob;
    logic          dbg_ack;
    logic [W-1:0]  dbg_rdata;

    qerv_rf_ram_resp #(.width(8), .csr_regs(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_wen       (wen),
        .i_raddr     (raddr),
        .i_ren       (ren),
        .o_rdata     (rdata),
        .o_init_done (init_done),
        .o_oob       (oob),
        .i_dbg_req   (dbg_req),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_ack   (dbg_ack),
        .o_dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, n_cycle, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] m_mem [DEPTH];
    int           m_edges;       // rising edges seen since reset release
    logic [W-1:0] m_rdata;
    logic         m_oob;
    logic         m_ack;
    logic [W-1:0] m_dbg;

    task automatic m_reset();
        m_edges = 0;
        m_rdata = '0;
        m_oob   = 1'b0;
        m_ack   = 1'b0;
        m_dbg   = '0;
    endtask

    // Word seen by a read this cycle: zero if out of range, write-first bypass.
    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) begin
            m_oob = 1'b1;
            return '0;
        end
        if (wen && waddr == a) return wdata;
        return m_mem[a];
    endfunction

    task automatic model_step();
        logic fire;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (m_edges < DEPTH) begin
            m_mem[m_edges] = '0;
            if (wen || ren) m_oob = 1'b1;
            m_edges++;
        end else begin
            fire = !ren && dbg_req && !m_ack;
            if (ren)  m_rdata = m_read(raddr);
            if (fire) m_dbg   = m_read(dbg_addr);
            m_ack = fire;
            if (wen) begin
                if (int'(waddr) < DEPTH) m_mem[waddr] = wdata;
                else                     m_oob = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        check("rdata",     32'(rdata),     32'(m_rdata));
        check("oob",       32'(oob),       32'(m_oob));
        check("init_done", 32'(init_done), 32'(m_edges >= DEPTH));
        check("dbg_ack",   32'(dbg_ack),   32'(m_ack));
        check("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg));
    endtask

    // One clock: update model from current inputs, clock the DUT, compare.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        n_cycle++;
        compare_model();
    endtask

    task automatic set_idle();
        wen = 0; waddr = '0; wdata = '0;
        ren = 0; raddr = '0;
        dbg_req = 0; dbg_addr = '0;
    endtask

    // Clock until init_done rises (bounded) and check the edge count.
    task automatic wait_sweep(input string name);
        int edges;
        edges = 0;
        while (!init_done && edges < 1000) begin
            cycle();
            edges++;
        end
        check(name, 32'(edges), 32'(DEPTH));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic          ren;
        logic [AW-1:0] raddr;
        logic          dreq;
        logic [AW-1:0] daddr;
        logic [W-1:0]  exp_rdata;
        logic          exp_oob;
        logic          exp_ack;
        logic [W-1:0]  exp_dbg;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit we, input int wa, input int wd, input bit re, input int ra,
                       input bit dq, input int da, input int er, input bit eo, input bit ea,
                       input int ed);
        vec_t v;
        v.wen = we; v.waddr = 8'(wa); v.wdata = 8'(wd);
        v.ren = re; v.raddr = 8'(ra);
        v.dreq = dq; v.daddr = 8'(da);
        v.exp_rdata = 8'(er); v.exp_oob = eo; v.exp_ack = ea; v.exp_dbg = 8'(ed);
        vq.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst_n = 0;
        m_reset();

        // Reset values.
        cycle();
        cycle();
        check("rst_rdata",     32'(rdata),     32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_oob",       32'(oob),       32'h0);
        check("rst_dbg_ack",   32'(dbg_ack),   32'h0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);

        rst_n = 1;
        wait_sweep("first_sweep_edges");

        // Fill with 0xA5 and confirm, then a one-cycle reset must re-zero everything.
        for (int a = 0; a < DEPTH; a++) begin
            wen = 1; waddr = 8'(a); wdata = 8'hA5;
            cycle();
        end
        set_idle();
        ren = 1; raddr = 8'd70;
        cycle();
        check("fill_a5", 32'(rdata), 32'hA5);
        set_idle();

        rst_n = 0;
        cycle();
        rst_n = 1;
        wait_sweep("resweep_edges");
        for (int a = 0; a < DEPTH; a++) begin
            ren = 1; raddr = 8'(a);
            cycle();
            check($sformatf("zero_%0d", a), 32'(rdata), 32'h0);
            check($sformatf("zero_oob_%0d", a), 32'(oob), 32'h0);
        end
        set_idle();

        // Directed table: basic R/W, collision, out of range, debug arbitration.
        //   wen wa   wd    ren ra   dq da   rdata oob ack dbg
        add(1, 17, 'h3C, 0, 0,   0, 0,   'h00, 0, 0, 'h00);
        add(0, 0,  0,    1, 17,  0, 0,   'h3C, 0, 0, 'h00);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 'h3C, 0, 0, 'h00);
        add(1, 40, 'h81, 1, 40,  0, 0,   'h81, 0, 0, 'h00);
        add(0, 0,  0,    1, 40,  0, 0,   'h81, 0, 0, 'h00);
        add(1, 5,  'h11, 0, 0,   0, 0,   'h81, 0, 0, 'h00);
        add(1, 200,'hFF, 0, 0,   0, 0,   'h81, 1, 0, 'h00);
        add(0, 0,  0,    1, 200, 0, 0,   'h00, 1, 0, 'h00);
        add(0, 0,  0,    1, 72,  0, 0,   'h00, 1, 0, 'h00);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 5, 1, 5, 'h11, 1, 0, 'h00);
        add(0, 0,  0,    0, 0,   1, 5,   'h11, 1, 1, 'h11);
        add(0, 0,  0,    0, 0,   0, 0,   'h11, 1, 0, 'h11);
        add(0, 0,  0,    0, 0,   1, 17,  'h11, 1, 1, 'h3C);
        add(0, 0,  0,    0, 0,   1, 17,  'h11, 1, 0, 'h3C);
        add(0, 0,  0,    0, 0,   1, 17,  'h11, 1, 1, 'h3C);
        add(0, 0,  0,    0, 0,   0, 0,   'h11, 1, 0, 'h3C);
        add(0, 0,  0,    0, 0,   1, 250, 'h11, 1, 1, 'h00);
        add(0, 0,  0,    0, 0,   0, 0,   'h11, 1, 0, 'h00);
        add(1, 9,  'h5A, 0, 0,   1, 9,   'h11, 1, 1, 'h5A);
        add(0, 0,  0,    0, 0,   0, 0,   'h11, 1, 0, 'h5A);

        foreach (vq[i]) begin
            wen = vq[i].wen; waddr = vq[i].waddr; wdata = vq[i].wdata;
            ren = vq[i].ren; raddr = vq[i].raddr;
            dbg_req = vq[i].dreq; dbg_addr = vq[i].daddr;
            cycle();
            check($sformatf("vec%0d_rdata", i), 32'(rdata),     32'(vq[i].exp_rdata));
            check($sformatf("vec%0d_oob", i),   32'(oob),       32'(vq[i].exp_oob));
            check($sformatf("vec%0d_ack", i),   32'(dbg_ack),   32'(vq[i].exp_ack));
            check($sformatf("vec%0d_dbg", i),   32'(dbg_rdata), 32'(vq[i].exp_dbg));
        end
        set_idle();

        // Reset mid-sweep at count 60 (asynchronous), then access during INIT.
        rst_n = 0;
        cycle();
        rst_n = 1;
        for (int i = 0; i < 60; i++) cycle();
        #2;
        rst_n = 0;
        m_reset();
        #1;
        check("async_rst_init_done", 32'(init_done), 32'h0);
        check("async_rst_oob",       32'(oob),       32'h0);
        cycle();
        rst_n = 1;
        begin
            int edges;
            edges = 0;
            while (!init_done && edges < 1000) begin
                if (edges == 10) begin
                    wen = 1; waddr = 8'd3; wdata = 8'h77;
                    ren = 1; raddr = 8'd3;
                end else begin
                    set_idle();
                end
                cycle();
                edges++;
                if (edges == 11) begin
                    check("init_access_oob",   32'(oob),   32'h1);
                    check("init_access_rdata", 32'(rdata), 32'h0);
                end
            end
            check("midsweep_edges", 32'(edges), 32'(DEPTH));
        end
        set_idle();
        ren = 1; raddr = 8'd3;
        cycle();
        check("init_write_dropped", 32'(rdata), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wen      = ($urandom_range(1, 0) == 1);
            waddr    = 8'($urandom_range(159, 0));
            wdata    = 8'($urandom);
            ren      = ($urandom_range(2, 0) == 0);
            raddr    = 8'($urandom_range(159, 0));
            dbg_req  = ($urandom_range(2, 0) != 0);
            dbg_addr = 8'($urandom_range(159, 0));
            cycle();
        end
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
